// File: rtl/m_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_cache_pkg
// Description : Shared geometry, state encoding and line packing helper for
//               the direct-mapped cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package m_cache_pkg;

    localparam int TAG_W     = 25;
    localparam int IDX_W     = 5;
    localparam int DATA_W    = 32;
    localparam int LINE_W    = 58;
    localparam int NUM_LINES = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MEM_REQ = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    // Line layout is {valid, tag, data}; tag is the address above index+offset.
    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] addr,
                                                    input logic [DATA_W-1:0] data);
        return {1'b1, addr[31:IDX_W+2], data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : m_sat_counter
// Description : 32-bit event counter that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module m_sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/m_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : m_cache_refill_ctrl
// Description : Read-miss refill and flush sequencer for a 32-line direct-
//               mapped cache. Optional hit/miss statistics are built when
//               CACHE_REFILL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module m_cache_refill_ctrl
    import m_cache_pkg::*;
#(
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic              w_clock,
    input  logic              w_reset_n,
    input  logic              w_req,
    input  logic [31:0]       w_addr,
    input  logic              w_flush,
    output logic              w_busy,
    output logic              w_rvalid,
    output logic [31:0]       w_rdata,
    output logic [31:0]       w_c_addr,
    input  logic              w_c_hit,
    input  logic [31:0]       w_c_dout,
    output logic              w_c_we,
    output logic [IDX_W-1:0]  w_c_wa,
    output logic [LINE_W-1:0] w_c_wd,
    output logic              w_m_req,
    output logic [31:0]       w_m_addr,
    input  logic              w_m_ack,
    input  logic [31:0]       w_m_rdata
`ifdef CACHE_REFILL_STATS_EN
    ,
    output logic [31:0]       w_hit_cnt,
    output logic [31:0]       w_miss_cnt
`endif
);

    logic [2:0]        r_state;
    logic [2:0]        w_nxt_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic              r_pend;
    logic [31:0]       r_addr;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_m_req;
    logic [31:0]       r_m_addr;
    logic              r_c_we;
    logic [IDX_W-1:0]  r_c_wa;
    logic [LINE_W-1:0] r_c_wd;

    // r_pend carries the post-reset flush request into the first IDLE edge.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (r_pend || w_flush) begin
                    w_nxt_state = S_FLUSH;
                    w_nxt_idx   = '0;
                end else if (w_req) begin
                    w_nxt_state = S_LOOKUP;
                end
            end
            S_LOOKUP:  w_nxt_state = w_c_hit ? S_RESP : S_MEM_REQ;
            S_MEM_REQ: if (w_m_ack) w_nxt_state = S_FILL;
            S_FILL:    w_nxt_state = S_RESP;
            S_RESP:    w_nxt_state = S_IDLE;
            S_FLUSH: begin
                if (r_idx == IDX_W'(NUM_LINES - 1)) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_idx = r_idx + 1'b1;
                end
            end
            default:   w_nxt_state = S_IDLE;
        endcase
    end

    // Cache/memory strobes are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_pend   <= FLUSH_ON_RESET;
            r_addr   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_m_req  <= 1'b0;
            r_m_addr <= '0;
            r_c_we   <= 1'b0;
            r_c_wa   <= '0;
            r_c_wd   <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_idx    <= w_nxt_idx;
            r_rvalid <= (r_state == S_RESP);
            if (r_state == S_IDLE) begin
                r_pend <= 1'b0;
                if (!(r_pend || w_flush) && w_req) r_addr <= w_addr;
            end
            if (r_state == S_LOOKUP && w_c_hit) r_rdata <= w_c_dout;
            if (r_state == S_MEM_REQ && w_m_ack) r_rdata <= w_m_rdata;
            if (r_state == S_LOOKUP && !w_c_hit) r_m_addr <= {r_addr[31:2], 2'b00};
            r_m_req <= (w_nxt_state == S_MEM_REQ);
            r_c_we  <= (w_nxt_state == S_FILL) || (w_nxt_state == S_FLUSH);
            case (w_nxt_state)
                S_FILL: begin
                    r_c_wa <= r_addr[IDX_W+1:2];
                    r_c_wd <= make_line(r_addr, w_m_rdata);
                end
                S_FLUSH: begin
                    r_c_wa <= w_nxt_idx;
                    r_c_wd <= '0;
                end
                default: begin
                    r_c_wa <= '0;
                    r_c_wd <= '0;
                end
            endcase
        end
    end

    assign w_busy   = (r_state != S_IDLE) && w_reset_n;
    assign w_rvalid = r_rvalid;
    assign w_rdata  = r_rdata;
    assign w_c_addr = r_addr;
    assign w_c_we   = r_c_we;
    assign w_c_wa   = r_c_wa;
    assign w_c_wd   = r_c_wd;
    assign w_m_req  = r_m_req;
    assign w_m_addr = r_m_addr;

`ifdef CACHE_REFILL_STATS_EN
    logic w_hit_inc;
    logic w_miss_inc;

    assign w_hit_inc  = (r_state == S_LOOKUP) && w_c_hit;
    assign w_miss_inc = (r_state == S_LOOKUP) && !w_c_hit;

    m_sat_counter u_hit_cnt (
        .clk   (w_clock),
        .rst_n (w_reset_n),
        .inc   (w_hit_inc),
        .count (w_hit_cnt)
    );

    m_sat_counter u_miss_cnt (
        .clk   (w_clock),
        .rst_n (w_reset_n),
        .inc   (w_miss_inc),
        .count (w_miss_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_cache_refill_ctrl
// Description : Directed self-checking bench for m_cache_refill_ctrl with a
//               behavioural 32-line cache array and a delayed-ack memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_cache_refill_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy, rvalid, c_hit, c_we, m_req;
    logic [31:0] rdata, c_addr, c_dout, m_addr;
    logic [4:0]  c_wa;
    logic [57:0] c_wd;
`ifdef CACHE_REFILL_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    m_cache_refill_ctrl u_dut (
        .w_clock   (clock),
        .w_reset_n (reset_n),
        .w_req     (req),
        .w_addr    (addr),
        .w_flush   (flush),
        .w_busy    (busy),
        .w_rvalid  (rvalid),
        .w_rdata   (rdata),
        .w_c_addr  (c_addr),
        .w_c_hit   (c_hit),
        .w_c_dout  (c_dout),
        .w_c_we    (c_we),
        .w_c_wa    (c_wa),
        .w_c_wd    (c_wd),
        .w_m_req   (m_req),
        .w_m_addr  (m_addr),
        .w_m_ack   (m_ack),
        .w_m_rdata (m_rdata)
`ifdef CACHE_REFILL_STATS_EN
        ,
        .w_hit_cnt  (hit_cnt),
        .w_miss_cnt (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural cache array: written by the DUT or by bench preloads.
    logic [57:0] mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [57:0] pre_val = '0;
    int          fill_cnt = 0;
    logic [57:0] line;

    always @(posedge clock) begin
        if (c_we) mem[c_wa] <= c_wd;
        else if (pre_en) mem[pre_idx] <= pre_val;
        if (c_we && c_wd[57]) fill_cnt <= fill_cnt + 1;
    end

    assign line   = mem[c_addr[6:2]];
    assign c_hit  = (line[57] === 1'b1) && (line[56:32] === c_addr[31:7]);
    assign c_dout = line[31:0];

    int          lat, nfill;
    logic        saw;
    logic [31:0] got, maddr;
    logic [4:0]  fwa;
    logic [57:0] fwd;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [57:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Issue one read and run it to the response, acking memory after ack_dly
    // cycles of w_m_req.
    task automatic do_req(input logic [31:0] a, input int ack_dly, input logic [31:0] d);
        int mcyc;
        req = 1'b1; addr = a;
        tick();
        req = 1'b0;
        lat = 0; mcyc = 0; saw = 1'b0; nfill = 0;
        maddr = '0; fwa = '0; fwd = '0;
        while (rvalid !== 1'b1 && lat < 60) begin
            if (m_req === 1'b1) begin
                saw = 1'b1; maddr = m_addr; mcyc++;
                if (mcyc == ack_dly) begin m_ack = 1'b1; m_rdata = d; end
            end
            tick();
            lat++;
            m_ack = 1'b0;
            if (c_we === 1'b1) begin nfill++; fwa = c_wa; fwd = c_wd; end
        end
        got = rdata;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if ({rvalid, m_req, c_we} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b want 000", {rvalid, m_req, c_we}); end
        n_cmp++; if (rdata !== 32'h0 || c_addr !== 32'h0 || m_addr !== 32'h0) begin n_bad++; $display("FAIL rst_regs: got %h/%h/%h want 0", rdata, c_addr, m_addr); end
        n_cmp++; if (c_wa !== 5'h0 || c_wd !== 58'h0) begin n_bad++; $display("FAIL rst_cwr: got %h/%h want 0", c_wa, c_wd); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || c_we !== 1'b1 || c_wa !== 5'd0) begin n_bad++; $display("FAIL rst_flush_start: got busy=%b we=%b wa=%0d want 1 1 0", busy, c_we, c_wa); end
        wait_idle(n);
        n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL rst_flush_len: got %0d want 32", n); end
    endtask

    task automatic test_hit();
        preload(5'd5, {1'b1, 25'h000_0001, 32'hDEAD_BEEF});
        do_req(32'h0000_0094, 1, 32'h0);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hit_lat: got %0d want 2", lat); end
        n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hit_data: got %h want deadbeef", got); end
        n_cmp++; if (saw !== 1'b0 || nfill !== 0) begin n_bad++; $display("FAIL hit_nomem: got mreq=%b fills=%0d want 0 0", saw, nfill); end
        tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL hit_pulse: got %b want 0", rvalid); end
    endtask

    task automatic test_miss();
        do_req(32'h1234_5678, 4, 32'hCAFE_F00D);
        n_cmp++; if (maddr !== 32'h1234_5678) begin n_bad++; $display("FAIL miss_maddr: got %h want 12345678", maddr); end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL miss_lat: got %0d want 7", lat); end
        n_cmp++; if (nfill !== 1 || fwa !== 5'h1E) begin n_bad++; $display("FAIL miss_fill_wa: got n=%0d wa=%h want 1 1e", nfill, fwa); end
        n_cmp++; if (fwd !== {1'b1, 25'h02468AC, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL miss_fill_wd: got %h want %h", fwd, {1'b1, 25'h02468AC, 32'hCAFE_F00D}); end
        n_cmp++; if (got !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL miss_data: got %h want cafef00d", got); end
        do_req(32'h1234_5678, 1, 32'h0);
        n_cmp++; if (lat !== 2 || saw !== 1'b0 || got !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL miss_rehit: got lat=%0d mreq=%b data=%h want 2 0 cafef00d", lat, saw, got); end
    endtask

    task automatic test_ack_ignored();
        tick();
        m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        tick(); tick();
        m_ack = 1'b0;
        n_cmp++; if (busy !== 1'b0 || c_we !== 1'b0 || rvalid !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got busy=%b we=%b rv=%b want 000", busy, c_we, rvalid); end
    endtask

    task automatic test_flush();
        int  n;
        logic ok;
        req = 1'b1; flush = 1'b1; addr = 32'h0000_0094;
        tick();
        req = 1'b0; flush = 1'b0;
        n = 0; ok = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (c_we !== 1'b1 || c_wa !== n[4:0] || c_wd !== 58'h0 || m_req !== 1'b0 || rvalid !== 1'b0) ok = 1'b0;
            n++;
            tick();
        end
        n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL flush_len: got %0d want 32", n); end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL flush_seq: got bad write sequence want wa 0..31 wd 0"); end
        n_cmp++; if (c_addr !== 32'h1234_5678 || rvalid !== 1'b0) begin n_bad++; $display("FAIL flush_drop: got addr=%h rv=%b want 12345678 0", c_addr, rvalid); end
        do_req(32'h0000_0094, 1, 32'h1111_2222);
        n_cmp++; if (saw !== 1'b1 || lat !== 4 || got !== 32'h1111_2222) begin n_bad++; $display("FAIL flush_then_miss: got mreq=%b lat=%0d data=%h want 1 4 11112222", saw, lat, got); end
    endtask

    task automatic test_reset_mid_miss();
        int n, f0;
        f0 = fill_cnt;
        req = 1'b1; addr = 32'h0000_0040;
        tick();
        req = 1'b0;
        n = 0;
        while (m_req !== 1'b1 && n < 10) begin n++; tick(); end
        n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL rmm_mreq: got %b want 1", m_req); end
        reset_n = 1'b0;
        tick();
        n_cmp++; if (m_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmm_drop: got mreq=%b busy=%b want 0 0", m_req, busy); end
        m_ack = 1'b1; m_rdata = 32'h5555_5555;
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || c_wd !== 58'h0 || c_addr !== 32'h0) begin n_bad++; $display("FAIL rmm_flush: got busy=%b wd=%h addr=%h want 1 0 0", busy, c_wd, c_addr); end
        m_ack = 1'b0;
        wait_idle(n);
        n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL rmm_flush_len: got %0d want 32", n); end
        n_cmp++; if (fill_cnt !== f0) begin n_bad++; $display("FAIL rmm_nofill: got %0d fills want %0d", fill_cnt, f0); end
    endtask

`ifdef CACHE_REFILL_STATS_EN
    task automatic test_stats();
        int n;
        reset_n = 1'b0;
        tick(); tick();
        n_cmp++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_bad++; $display("FAIL stats_rst: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        reset_n = 1'b1;
        tick();
        wait_idle(n);
        preload(5'd5, {1'b1, 25'h000_0001, 32'hDEAD_BEEF});
        for (int i = 0; i < 3; i++) do_req(32'h0000_0094, 1, 32'h0);
        do_req(32'h1000_0000, 2, 32'h1);
        do_req(32'h2000_0004, 1, 32'h2);
        n_cmp++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin n_bad++; $display("FAIL stats_cnt: got %0d/%0d want 3/2", hit_cnt, miss_cnt); end
        u_dut.u_hit_cnt.r_count = 32'hFFFF_FFFE;
        do_req(32'h0000_0094, 1, 32'h0);
        do_req(32'h0000_0094, 1, 32'h0);
        n_cmp++; if (hit_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL stats_sat: got %h want ffffffff", hit_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_ack_ignored();
        test_flush();
        test_reset_mid_miss();
`ifdef CACHE_REFILL_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
